// File: rtl/alu_ext_pkg.sv
// Shared definitions for the iterative ALU extension.
// Contents:
//   ALU_DATA_WIDTH / ALU_CNT_WIDTH : default operand and step-counter widths
//   alu_op_e                       : opcode encodings (MUL, SLL, SRL, SRA, ROR)
//   alu_state_e                    : FSM state encodings (IDLE, RUN, FIN)
package alu_ext_pkg;

  localparam int ALU_DATA_WIDTH = 8;
  localparam int ALU_CNT_WIDTH  = 4;

  typedef enum logic [2:0] {
    MUL = 3'b000,
    SLL = 3'b001,
    SRL = 3'b010,
    SRA = 3'b011,
    ROR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/iter_alu_ext_if.sv
// Request/response bundle between the register file / control logic and
// iter_alu_ext.
// Handshake: START is a single-cycle request sampled on the rising clock
// edge; it is accepted only while the unit is not busy (IDLE or FIN) and is
// ignored while BUSY=1. OPCODE/DATA1/DATA2 only need to be valid on the
// accepting edge. DONE pulses for one cycle when RESULT becomes valid;
// RESULT then holds until the next accepted START.
// Signals:
//   START, OPCODE, DATA1, DATA2 : requester -> ALU
//   RESULT, BUSY, DONE          : ALU -> requester
//   STATE                       : ALU -> observer, FSM state for debug
// Modports: master (requester side), slave (ALU side).
interface iter_alu_ext_if
  import alu_ext_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
);
  logic                  START;
  logic [2:0]            OPCODE;
  logic [DATA_WIDTH-1:0] DATA1;
  logic [DATA_WIDTH-1:0] DATA2;
  logic [DATA_WIDTH-1:0] RESULT;
  logic                  BUSY;
  logic                  DONE;
  alu_state_e            STATE;

  modport master (
    output START, OPCODE, DATA1, DATA2,
    input  RESULT, BUSY, DONE, STATE
  );

  modport slave (
    input  START, OPCODE, DATA1, DATA2,
    output RESULT, BUSY, DONE, STATE
  );
endinterface

// File: rtl/alu_ext_step.sv
// Combinational single-step datapath for iter_alu_ext.
// MUL performs one shift-add step on (acc, multiplicand, multiplier);
// shift opcodes move acc by one bit position. Unknown opcodes hold state.
// Ports:
//   i_opcode  : operation select
//   i_acc     : accumulator / value being shifted
//   i_mcand   : multiplicand (MUL only)
//   i_mplier  : remaining multiplier (MUL only)
//   o_acc, o_mcand, o_mplier : values after one step
module alu_ext_step
  import alu_ext_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [2:0]            i_opcode,
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_mcand,
  input  logic [DATA_WIDTH-1:0] i_mplier,
  output logic [DATA_WIDTH-1:0] o_acc,
  output logic [DATA_WIDTH-1:0] o_mcand,
  output logic [DATA_WIDTH-1:0] o_mplier
);

  always_comb begin
    o_acc    = i_acc;
    o_mcand  = i_mcand;
    o_mplier = i_mplier;
    case (i_opcode)
      MUL: begin
        // Accumulator keeps only the low DATA_WIDTH bits; overflow drops.
        if (i_mplier[0]) o_acc = i_acc + i_mcand;
        o_mcand  = i_mcand << 1;
        o_mplier = i_mplier >> 1;
      end
      SLL:     o_acc = i_acc << 1;
      SRL:     o_acc = i_acc >> 1;
      SRA:     o_acc = {i_acc[DATA_WIDTH-1], i_acc[DATA_WIDTH-1:1]};
      ROR:     o_acc = {i_acc[0], i_acc[DATA_WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_alu_ext.sv
// Multi-cycle ALU extension: MUL, SLL, SRL, SRA, ROR, one bit per cycle.
// Sits behind the register-file read ports; RESULT feeds the write-data mux,
// DONE qualifies the register-file write and BUSY stalls the PC.
// Ports:
//   CLOCK : system clock, all state on posedge
//   RESET : synchronous, active-high
//   bus   : iter_alu_ext_if.slave (START/OPCODE/DATA1/DATA2 in,
//           RESULT/BUSY/DONE/STATE out)
// Optional feature macro: ITER_ALU_EARLY_EXIT_EN -- when defined, MUL stops
// after the highest set bit of the multiplier instead of running all steps.
module iter_alu_ext
  import alu_ext_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int CNT_WIDTH  = ALU_CNT_WIDTH
) (
  input logic          CLOCK,
  input logic          RESET,
  iter_alu_ext_if.slave bus
);

  alu_state_e            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_busy;
  logic                  r_done;

  logic [CNT_WIDTH-1:0]  w_steps;
  logic [DATA_WIDTH-1:0] w_zero_result;
  logic [DATA_WIDTH-1:0] w_acc_init;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0] w_mcand_next;
  logic [DATA_WIDTH-1:0] w_mplier_next;

  // Step count and zero-step result for the request currently on the bus.
  always_comb begin
    w_steps       = '0;
    w_zero_result = '0;
    w_acc_init    = bus.DATA1;
    case (bus.OPCODE)
      MUL: begin
        w_acc_init = '0;
`ifdef ITER_ALU_EARLY_EXIT_EN
        // Latency is the index of the top set multiplier bit plus one.
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (bus.DATA2[i]) w_steps = CNT_WIDTH'(i + 1);
        end
`else
        w_steps = CNT_WIDTH'(DATA_WIDTH);
`endif
      end
      SLL, SRL, SRA: begin
        // Any amount of DATA_WIDTH or more saturates at DATA_WIDTH steps,
        // which already yields all-zero / all-sign-bit results.
        w_steps = (int'(bus.DATA2) >= DATA_WIDTH) ? CNT_WIDTH'(DATA_WIDTH)
                                                  : CNT_WIDTH'(bus.DATA2);
        w_zero_result = bus.DATA1;
      end
      ROR: begin
        w_steps       = CNT_WIDTH'(int'(bus.DATA2) % DATA_WIDTH);
        w_zero_result = bus.DATA1;
      end
      default: w_acc_init = '0;
    endcase
  end

  alu_ext_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_opcode (r_op),
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_next),
    .o_mcand  (w_mcand_next),
    .o_mplier (w_mplier_next)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (bus.START) begin
            r_op     <= bus.OPCODE;
            r_acc    <= w_acc_init;
            r_mcand  <= bus.DATA1;
            r_mplier <= bus.DATA2;
            r_cnt    <= w_steps;
            if (w_steps == '0) begin
              r_state  <= FIN;
              r_result <= w_zero_result;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= w_mcand_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt - 1'b1;
          // The edge performing the final step publishes the result.
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_state  <= FIN;
            r_result <= w_acc_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RESULT = r_result;
  assign bus.BUSY   = r_busy;
  assign bus.DONE   = r_done;
  assign bus.STATE  = r_state;

endmodule

// File: tb/tb_iter_alu_ext.sv
module tb_iter_alu_ext;
  import alu_ext_pkg::*;

`ifdef ITER_ALU_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_alu_ext_if #(.DATA_WIDTH(8)) bus ();

  iter_alu_ext u_dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // driver: issue one request at the current negedge, return at the negedge
  // where DONE is seen (or timeout). lat = edges after the accepting edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int lat,
                        output int busy_cnt, output logic [7:0] res);
    bus.START = 1'b1; bus.OPCODE = op; bus.DATA1 = a; bus.DATA2 = b;
    @(posedge clk); #1 bus.START = 1'b0;
    @(negedge clk);
    lat = 0; busy_cnt = 0;
    while (bus.DONE !== 1'b1 && lat < 40) begin
      if (bus.BUSY === 1'b1) busy_cnt++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    res = bus.RESULT;
    if (lat >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL timeout op=%0d a=%h b=%h: no DONE within %0d edges", op, a, b, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 1'b1; bus.OPCODE = 3'(SLL); bus.DATA1 = 8'h01; bus.DATA2 = 8'h00;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.RESULT !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", bus.RESULT); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    n_checks++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    n_checks++; if (bus.STATE !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.STATE); end
    rst = 1'b0; bus.START = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat, bc; logic [7:0] res;
    run_op(3'(MUL), 8'd13, 8'd11, lat, bc, res);
    n_checks++; if (res !== 8'h8F) begin n_fail++; $display("FAIL mul13x11_result got=%h exp=8f", res); end
    n_checks++; if (lat !== (EE ? 4 : 8)) begin n_fail++; $display("FAIL mul13x11_latency got=%0d exp=%0d", lat, EE ? 4 : 8); end
    n_checks++; if (bc !== (EE ? 4 : 8)) begin n_fail++; $display("FAIL mul13x11_busy_cycles got=%0d exp=%0d", bc, EE ? 4 : 8); end
    @(negedge clk);
    n_checks++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse got=%b exp=0", bus.DONE); end
    n_checks++; if (bus.RESULT !== 8'h8F) begin n_fail++; $display("FAIL result_hold got=%h exp=8f", bus.RESULT); end
    run_op(3'(MUL), 8'd20, 8'd20, lat, bc, res);
    n_checks++; if (res !== 8'h90) begin n_fail++; $display("FAIL mul20x20_result got=%h exp=90", res); end
    n_checks++; if (lat !== (EE ? 5 : 8)) begin n_fail++; $display("FAIL mul20x20_latency got=%0d exp=%0d", lat, EE ? 5 : 8); end
    @(negedge clk);
  endtask

  task automatic test_shift();
    int lat, bc; logic [7:0] res;
    run_op(3'(SRA), 8'h90, 8'd3, lat, bc, res);
    n_checks++; if (res !== 8'hF2) begin n_fail++; $display("FAIL sra_90_3_result got=%h exp=f2", res); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sra_90_3_latency got=%0d exp=3", lat); end
    @(negedge clk);
    run_op(3'(SRL), 8'h90, 8'd200, lat, bc, res);
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL srl_90_200_result got=%h exp=00", res); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL srl_90_200_latency got=%0d exp=8", lat); end
    @(negedge clk);
    run_op(3'(SRL), 8'h90, 8'd4, lat, bc, res);
    n_checks++; if (res !== 8'h09) begin n_fail++; $display("FAIL srl_90_4_result got=%h exp=09", res); end
    @(negedge clk);
    run_op(3'(SRA), 8'h90, 8'd8, lat, bc, res);
    n_checks++; if (res !== 8'hFF) begin n_fail++; $display("FAIL sra_90_8_result got=%h exp=ff", res); end
    @(negedge clk);
    run_op(3'(SLL), 8'hA5, 8'd255, lat, bc, res);
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL sll_a5_255_result got=%h exp=00", res); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL sll_a5_255_latency got=%0d exp=8", lat); end
    @(negedge clk);
    run_op(3'(SLL), 8'h21, 8'd2, lat, bc, res);
    n_checks++; if (res !== 8'h84) begin n_fail++; $display("FAIL sll_21_2_result got=%h exp=84", res); end
    @(negedge clk);
    run_op(3'(SLL), 8'h01, 8'd0, lat, bc, res);
    n_checks++; if (res !== 8'h01) begin n_fail++; $display("FAIL sll_01_0_result got=%h exp=01", res); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL sll_01_0_latency got=%0d exp=0", lat); end
    @(negedge clk);
  endtask

  task automatic test_ror();
    int lat, bc; logic [7:0] res;
    run_op(3'(ROR), 8'h81, 8'd9, lat, bc, res);
    n_checks++; if (res !== 8'hC0) begin n_fail++; $display("FAIL ror_81_9_result got=%h exp=c0", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ror_81_9_latency got=%0d exp=1", lat); end
    @(negedge clk);
    run_op(3'(ROR), 8'h12, 8'd4, lat, bc, res);
    n_checks++; if (res !== 8'h21) begin n_fail++; $display("FAIL ror_12_4_result got=%h exp=21", res); end
    @(negedge clk);
    run_op(3'(ROR), 8'h81, 8'd16, lat, bc, res);
    n_checks++; if (res !== 8'h81) begin n_fail++; $display("FAIL ror_81_16_result got=%h exp=81", res); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL ror_81_16_latency got=%0d exp=0", lat); end
    @(negedge clk);
    run_op(3'b111, 8'h55, 8'd3, lat, bc, res);
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL undef_op_result got=%h exp=00", res); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL undef_op_latency got=%0d exp=0", lat); end
    @(negedge clk);
  endtask

  // A second request launched straight from FIN must be accepted.
  task automatic test_back_to_back();
    int lat, bc; logic [7:0] res;
    run_op(3'(SRL), 8'hF0, 8'd2, lat, bc, res);
    n_checks++; if (res !== 8'h3C) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=3c", res); end
    run_op(3'(SLL), 8'h03, 8'd3, lat, bc, res);
    n_checks++; if (res !== 8'h18) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=18", res); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=3", lat); end
    @(negedge clk);
    n_checks++; if (bus.STATE !== IDLE) begin n_fail++; $display("FAIL b2b_return_idle got=%0d exp=0", bus.STATE); end
  endtask

  task automatic test_restart_ignored();
    int lat;
    bus.START = 1'b1; bus.OPCODE = 3'(MUL); bus.DATA1 = 8'hFF; bus.DATA2 = 8'hFF;
    @(posedge clk); #1 bus.START = 1'b0;
    @(negedge clk);
    lat = 0;
    while (bus.DONE !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        bus.START = 1'b1; bus.OPCODE = 3'(SLL); bus.DATA1 = 8'h01; bus.DATA2 = 8'h01;
      end
      @(posedge clk); lat++;
      #1 bus.START = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL restart_latency got=%0d exp=8", lat); end
    n_checks++; if (bus.RESULT !== 8'h01) begin n_fail++; $display("FAIL restart_result got=%h exp=01", bus.RESULT); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.START = 1'b1; bus.OPCODE = 3'(MUL); bus.DATA1 = 8'hFF; bus.DATA2 = 8'hFF;
    @(posedge clk); #1 bus.START = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", bus.BUSY); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.STATE !== IDLE) begin n_fail++; $display("FAIL midreset_state got=%0d exp=0", bus.STATE); end
    n_checks++; if (bus.RESULT !== 8'h00) begin n_fail++; $display("FAIL midreset_result got=%h exp=00", bus.RESULT); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", bus.BUSY); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.DONE === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_early_exit();
    int lat, bc; logic [7:0] res;
    run_op(3'(MUL), 8'd13, 8'd1, lat, bc, res);
    n_checks++; if (res !== 8'h0D) begin n_fail++; $display("FAIL mul13x1_result got=%h exp=0d", res); end
    n_checks++; if (lat !== (EE ? 1 : 8)) begin n_fail++; $display("FAIL mul13x1_latency got=%0d exp=%0d", lat, EE ? 1 : 8); end
    @(negedge clk);
    run_op(3'(MUL), 8'd7, 8'd0, lat, bc, res);
    n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL mul7x0_result got=%h exp=00", res); end
    n_checks++; if (lat !== (EE ? 0 : 8)) begin n_fail++; $display("FAIL mul7x0_latency got=%0d exp=%0d", lat, EE ? 0 : 8); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.START = 1'b0; bus.OPCODE = '0; bus.DATA1 = '0; bus.DATA2 = '0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_shift();
    test_ror();
    test_back_to_back();
    test_restart_ignored();
    test_reset_mid();
    test_early_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
